// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the derived sync positions.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;
    localparam int unsigned DEF_CW        = 10;

    localparam int unsigned DEF_H_TOTAL  = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned DEF_VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Registered per-pixel decode results, kept together so they share one register.
    typedef struct packed {
        logic video_on;
        logic hs_set;
        logic hs_reset;
        logic vs_set;
        logic vs_reset;
        logic frame_start;
    } sync_flags_t;

endpackage

// File: rtl/mod_counter.sv
// Mod-N counter; resets to N-1 so the first increment lands on 0.
module mod_counter #(
    parameter int unsigned N  = 800,
    parameter int unsigned CW = 10
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          wrap
);

    // Any value at or above N-1 wraps, so out-of-range counts self-recover.
    assign wrap = (count >= CW'(N - 1));

    // Count register: advance on inc, wrap to zero at the terminal value.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            count <= CW'(N - 1);
        else if (inc)
            count <= wrap ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical VGA timing: counters plus registered sync strobes and video_on.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_timing_pkg::DEF_H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::DEF_H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::DEF_H_BACK,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::DEF_V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::DEF_V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::DEF_V_BACK,
    parameter int unsigned CW        = vga_timing_pkg::DEF_CW
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          video_on,
    output logic          hs_set,
    output logic          hs_reset,
    output logic          vs_set,
    output logic          vs_reset,
    output logic          frame_start
);

    import vga_timing_pkg::*;

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    sync_flags_t   flags_next;
    sync_flags_t   flags_q;

    mod_counter #(.N(H_TOTAL), .CW(CW)) u_hcnt (
        .clock (clock),
        .clear (clear),
        .inc   (enable),
        .count (hcount),
        .wrap  (h_wrap)
    );

    mod_counter #(.N(V_TOTAL), .CW(CW)) u_vcnt (
        .clock (clock),
        .clear (clear),
        .inc   (enable & h_wrap),
        .count (vcount),
        .wrap  (v_wrap)
    );

    // Decode from the counts the counters will hold after this tick, so the
    // registered flags line up with the hcount/vcount shown in the same cycle.
    always_comb begin
        h_next     = h_wrap ? '0 : hcount + 1'b1;
        v_next     = h_wrap ? (v_wrap ? '0 : vcount + 1'b1) : vcount;
        flags_next = '0;
        flags_next.video_on    = (h_next < CW'(H_VISIBLE)) && (v_next < CW'(V_VISIBLE));
        flags_next.hs_set      = (h_next == CW'(HS_START));
        flags_next.hs_reset    = (h_next == CW'(HS_END));
        flags_next.vs_set      = (v_next == CW'(VS_START)) && (h_next == '0);
        flags_next.vs_reset    = (v_next == CW'(VS_END)) && (h_next == '0);
        flags_next.frame_start = (h_next == '0) && (v_next == '0);
    end

    // Output register: updates only on pixel ticks, cleared asynchronously.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            flags_q <= '0;
        else if (enable)
            flags_q <= flags_next;
    end

    assign video_on    = flags_q.video_on;
    assign hs_set      = flags_q.hs_set;
    assign hs_reset    = flags_q.hs_reset;
    assign vs_set      = flags_q.vs_set;
    assign vs_reset    = flags_q.vs_reset;
    assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance plus a small-geometry instance for frame-level checks.
module tb_vga_sync_gen;

    logic clock = 1'b0;
    logic clear = 1'b1;
    logic enable = 1'b1;

    // default geometry instance
    logic [9:0] dh, dv;
    logic dvid, dhss, dhsr, dvss, dvsr, dfs;
    // small geometry: H 16/4/6/6 (total 32, hs 20..26), V 12/2/2/3 (total 19, vs 14..16)
    logic [5:0] sh, sv;
    logic svid, shss, shsr, svss, svsr, sfs;

    logic q;  // hsync ffsr model driven by the default instance

    int vectors = 0;
    int miscompares = 0;
    int qhigh, nset, nrst, nfs, nhs;

    always #5 clock = ~clock;

    vga_sync_gen d (
        .clock(clock), .clear(clear), .enable(enable),
        .hcount(dh), .vcount(dv), .video_on(dvid),
        .hs_set(dhss), .hs_reset(dhsr), .vs_set(dvss), .vs_reset(dvsr),
        .frame_start(dfs)
    );

    vga_sync_gen #(
        .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CW(6)
    ) s (
        .clock(clock), .clear(clear), .enable(enable),
        .hcount(sh), .vcount(sv), .video_on(svid),
        .hs_set(shss), .hs_reset(shsr), .vs_set(svss), .vs_reset(svsr),
        .frame_start(sfs)
    );

    // ffsr: set wins, shares the async clear
    always @(posedge clock or posedge clear) begin
        if (clear)      q <= 1'b0;
        else if (dhss)  q <= 1'b1;
        else if (dhsr)  q <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clock);
        #1;
        check("rst_h", 32'(dh), 799);
        check("rst_v", 32'(dv), 524);
        check("rst_flags", 32'({dvid, dhss, dhsr, dvss, dvsr, dfs}), 0);
        check("rst_sh", 32'(sh), 31);
        check("rst_sv", 32'(sv), 18);
        check("rst_sflags", 32'({svid, shss, shsr, svss, svsr, sfs}), 0);
        clear = 1'b0;

        // first tick
        tick(1);
        check("t1_h", 32'(dh), 0);
        check("t1_v", 32'(dv), 0);
        check("t1_vid", 32'(dvid), 1);
        check("t1_fs", 32'(dfs), 1);
        check("t1_s_fs", 32'({sh, sv, sfs}), 1);

        // hsync start at tick 657
        tick(656);
        check("hs_h", 32'(dh), 656);
        check("hs_set", 32'(dhss), 1);
        check("hs_rst_lo", 32'(dhsr), 0);
        check("q_before", 32'(q), 0);
        qhigh = 0;
        for (int i = 0; i < 96; i++) begin
            tick(1);
            if (q) qhigh++;
        end
        check("hr_h", 32'(dh), 752);
        check("hs_reset", 32'(dhsr), 1);
        check("hs_set_lo", 32'(dhss), 0);
        tick(1);
        check("q_after", 32'(q), 0);
        check("q_width", 32'(qhigh), 96);

        // line wrap
        tick(46);
        check("lw_h799", 32'(dh), 799);
        check("lw_v0", 32'(dv), 0);
        check("lw_vid0", 32'(dvid), 0);
        tick(1);
        check("lw_h0", 32'(dh), 0);
        check("lw_v1", 32'(dv), 1);
        check("lw_vid1", 32'(dvid), 1);
        check("lw_fs0", 32'(dfs), 0);
        tick(639);
        check("vid_639", 32'(dvid), 1);
        tick(1);
        check("h_640", 32'(dh), 640);
        check("vid_640", 32'(dvid), 0);

        // mid-frame clear at (300,2)
        tick(460);
        check("mid_h", 32'(dh), 300);
        check("mid_v", 32'(dv), 2);
        check("mid_vid", 32'(dvid), 1);
        clear = 1'b1;
        #1;
        check("clr_h", 32'(dh), 799);
        check("clr_v", 32'(dv), 524);
        check("clr_flags", 32'({dvid, dfs, q}), 0);
        tick(1);
        clear = 1'b0;
        check("clr_hold_h", 32'(dh), 799);
        tick(1);
        check("resume_hv", 32'({dh, dv}), 0);
        check("resume_fs", 32'(dfs), 1);

        // small instance: vsync strobes and frame wrap
        nset = 0; nrst = 0; nfs = 0;
        for (int i = 0; i < 608; i++) begin
            tick(1);
            if (svss) begin
                nset++;
                check("vs_set_h", 32'(sh), 0);
                check("vs_set_v", 32'(sv), 14);
            end
            if (svsr) begin
                nrst++;
                check("vs_rst_h", 32'(sh), 0);
                check("vs_rst_v", 32'(sv), 16);
            end
            if (sfs) nfs++;
        end
        check("vs_set_cnt", 32'(nset), 1);
        check("vs_rst_cnt", 32'(nrst), 1);
        check("fs_cnt", 32'(nfs), 1);
        check("frame_wrap_hv", 32'({sh, sv}), 0);
        check("frame_wrap_fs", 32'(sfs), 1);

        // enable gating at half rate
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        nhs = 0;
        for (int i = 0; i < 700; i++) begin
            enable = 1'b1;
            tick(1);
            if (dhss) nhs++;
            enable = 1'b0;
            tick(1);
            if (dhss) nhs++;
            if (i == 10) check("hold_h", 32'(dh), 10);
        end
        enable = 1'b1;
        check("gate_hs_width", 32'(nhs), 2);
        check("gate_h", 32'(dh), 699);
        check("gate_v", 32'(dv), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
